// File: rtl/dmem_seq_ctrl_pkg.sv
// Shared data-memory sequencer definitions: FSM encoding, legal byte-lane masks
// and mask helpers used by the sequencer and the decoder.
package dmem_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_B1 = 4'b0010;
  localparam logic [3:0] MASK_B2 = 4'b0100;
  localparam logic [3:0] MASK_B3 = 4'b1000;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic mask_legal(input logic [3:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3, MASK_H0, MASK_H1, MASK_W: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Index of the lowest enabled lane; this is the byte shift for load extraction.
  function automatic logic [1:0] lane_shift(input logic [3:0] m);
    logic [1:0] s;
    s = 2'd0;
    if (m[0])      s = 2'd0;
    else if (m[1]) s = 2'd1;
    else if (m[2]) s = 2'd2;
    else if (m[3]) s = 2'd3;
    return s;
  endfunction

endpackage

// File: rtl/dmem_seq_ctrl_load_align.sv
// Load alignment: shifts the memory word down to the addressed lane and extends it.
// Purely combinational, no handshake.
module dmem_seq_ctrl_load_align
  import dmem_seq_ctrl_pkg::*;
(
  input  logic [3:0]  mask,
  input  logic [31:0] rdata,
  input  logic        rd_sign,
  output logic [31:0] data
);

  logic [31:0] word;
  logic        ext;

  always_comb begin
    word = rdata >> {lane_shift(mask), 3'b000};
    ext  = 1'b0;
    data = word;
    case (mask)
      MASK_B0, MASK_B1, MASK_B2, MASK_B3: begin
        ext  = ~rd_sign & word[7];
        data = {{24{ext}}, word[7:0]};
      end
      MASK_H0, MASK_H1: begin
        ext  = ~rd_sign & word[15];
        data = {{16{ext}}, word[15:0]};
      end
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_seq_ctrl.sv
// Data-memory access sequencer: min 2 stall cycles per access (request, ack), then a
// 1-cycle DONE; holds mem_req until mem_ack and aborts after TIMEOUT cycles without ack.
module dmem_seq_ctrl
  import dmem_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  re,
  input  logic [3:0]  we,
  input  logic        rd_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]      re_q, re_d;
  logic            rd_sign_q, rd_sign_d;
  logic            mem_req_q, mem_req_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [3:0]      mem_we_q, mem_we_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [31:0]     load_data_q, load_data_d;
  logic            load_valid_q, load_valid_d;
  logic            err_q, err_d;
  logic [31:0]     aligned;
  logic [3:0]      req_mask;

  dmem_seq_ctrl_load_align u_load_align (
    .mask    (re_q),
    .rdata   (mem_rdata),
    .rd_sign (rd_sign_q),
    .data    (aligned)
  );

  // Stores take priority when the decoder raises both masks.
  assign req_mask = (we != 4'd0) ? we : re;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    re_d         = re_q;
    rd_sign_d    = rd_sign_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = mem_we_q;
    mem_wdata_d  = mem_wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_mask != 4'd0) begin
          if (mask_legal(req_mask)) begin
            state_d     = BUSY;
            mem_req_d   = 1'b1;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_we_d    = we;
            mem_wdata_d = wdata << {addr[1:0], 3'b000};
            re_d        = (we != 4'd0) ? 4'd0 : re;
            rd_sign_d   = rd_sign;
          end else begin
            state_d     = DONE;
            err_d       = 1'b1;
            load_data_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 4'd0;
          cnt_d     = '0;
          if (re_q != 4'd0) begin
            load_valid_d = 1'b1;
            load_data_d  = aligned;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          mem_req_d   = 1'b0;
          mem_we_d    = 4'd0;
          cnt_d       = '0;
          err_d       = 1'b1;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      re_q         <= 4'd0;
      rd_sign_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 4'd0;
      mem_wdata_q  <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      re_q         <= re_d;
      rd_sign_q    <= rd_sign_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end

  assign stall      = ((state_q == IDLE) && ((re | we) != 4'd0)) || (state_q == BUSY);
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign err        = err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: doc/dmem_seq_ctrl.md
Name: dmem_seq_ctrl

Overview:
- Multi-cycle sequencer between the decoder's data-memory controls (re/we byte-lane masks, rd_sign) and a data memory with a req/ack handshake and variable latency.
- Stalls the core while an access is outstanding.
- Steers store data onto byte lanes and extracts, aligns and sign/zero-extends load data for the rd_sel=1 writeback path.
- Guards against a hung memory with a timeout.

Parameters:
- TIMEOUT, 16, max cycles mem_req may stay high without mem_ack before the access is aborted (range 1..255).
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge
- reset  input  1  asynchronous, active-high reset
- re  input  4  load byte-lane mask from decoder (1,2,4,8,3,12,15 legal)
- we  input  4  store byte-lane mask from decoder (same legal set)
- rd_sign  input  1  1 = unsigned load (LBU/LHU), 0 = signed
- addr  input  32  effective address (ALU output)
- wdata  input  32  store source (rs2), unshifted
- stall  output  1  hold PC/pipeline this cycle
- load_data  output  32  aligned, extended load result
- load_valid  output  1  one-cycle pulse: load_data valid, rf write allowed
- err  output  1  one-cycle pulse: illegal request or timeout
- mem_req  output  1  memory request, held until ack
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_we  output  4  byte write enables (0 for loads)
- mem_wdata  output  32  lane-shifted store data
- mem_rdata  input  32  memory read word, valid with mem_ack
- mem_ack  input  1  access complete

Behaviour:
- States: IDLE, BUSY, DONE. Reset puts the FSM in IDLE. Every registered output resets to 0: mem_req, mem_addr, mem_we, mem_wdata, load_data, load_valid, err, and the timeout counter.
- stall is combinational: 1 when in IDLE with (re|we)!=0, or when in BUSY; 0 in DONE.
- IDLE:
  - we!=0 takes priority over re. If both are nonzero, the store is performed and the load is ignored.
  - A legal mask is latched with addr, wdata and rd_sign; the FSM goes to BUSY.
  - mem_req=1, mem_addr=word address, mem_we=we (0 for a load), mem_wdata=wdata<<(8*addr[1:0]). All registered, so they are visible from the first BUSY cycle.
  - An illegal mask (not in the legal set) causes no memory access: err pulses in the following cycle (the FSM goes to DONE with err=1).
- BUSY:
  - mem_req held high; all request fields held stable.
  - The counter increments each cycle mem_ack=0.
  - mem_ack=1, including in the first BUSY cycle: drop mem_req; for a load, capture the extracted result into load_data and set load_valid=1; go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: drop mem_req, err=1, load_valid=0, load_data=0, go to DONE.
  - If mem_ack and timeout occur in the same cycle, ack wins.
- DONE: lasts exactly 1 cycle with stall=0, so the core retires the instruction at this edge. load_valid/err clear on exit. Next state is IDLE.
- Minimum latency: request in cycle N, ack in N+1, DONE in N+2 (2 stall cycles).
- Load extraction: lane shift s = index of the lowest set bit in the latched re; word = mem_rdata >> 8*s.
  - Byte masks: low 8 bits, sign-extended from bit 7 unless rd_sign=1.
  - Halfword masks: low 16 bits, extended from bit 15 unless rd_sign=1.
  - Mask 15: full word, rd_sign ignored.
- Stores never pulse load_valid.
- Asserting reset mid-BUSY drops mem_req immediately (async), abandons the access and returns to IDLE. A late mem_ack in IDLE is ignored.
- mem_ack is ignored in IDLE and DONE.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, BUSY=1, DONE=2) and the legal lane-mask constants (MASK_B0..MASK_B3, MASK_H0, MASK_H1, MASK_W), reused by the decoder.
- One sub-module, load_align: a combinational mask + rdata + rd_sign -> extended data block, also reusable by a future cache.

Test Plan:
- LW at addr 0x104, ack in the first BUSY cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x104, mem_we=0, 2 stall cycles, load_valid with load_data=0xDEADBEEF.
- LB (re=4'b0100, rd_sign=0) at addr 0x22, mem_rdata=0x1280_3456 -> load_data=0xFFFFFF80. Same with rd_sign=1 -> 0x00000080.
- SH (we=4'b1100) at addr 0x32, wdata=0x0000ABCD, ack after 5 cycles -> mem_addr=0x30, mem_we=4'b1100, mem_wdata=0xABCD0000, stall high for 6 cycles, no load_valid.
- No ack with TIMEOUT=16 -> mem_req high for exactly 16 cycles, then err pulse, load_valid=0, FSM back to IDLE. Ack in the 16th cycle -> normal completion, no err.
- Illegal mask re=4'b0101 -> no mem_req ever, err pulse 1 cycle later, stall released in DONE.
- Reset asserted in the 3rd BUSY cycle -> mem_req=0 asynchronously, all outputs 0. A mem_ack in the next cycle is ignored, and the next request proceeds normally.
